// File: rtl/row_shuffler.sv
// rtl/row_shuffler.sv - LFSR-driven Fisher-Yates shuffler streaming a one-hot permutation (option: ROW_SHUFFLER_IDENTITY_EN)
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module row_shuffler #(
    parameter int          W    = `GRID_LEN,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    output logic         busy,
    output logic         wr_en,
    output logic [W-1:0] wr_index,
    output logic [W-1:0] wr_value,
    output logic         done
);
    localparam int          K        = $clog2(W);
    localparam int          KW       = (K > 0) ? K : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [KW-1:0] LAST   = KW'(W - 1);

    typedef enum logic [1:0] {IDLE, PICK, EMIT, FIN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   pool [W];
    logic [KW-1:0]  k;
    logic [15:0]    lfsr;

`ifndef ROW_SHUFFLER_IDENTITY_EN
    logic [KW-1:0]  i;
    logic [KW-1:0]  j;
    logic           accept;

    // Candidates beyond the cursor are rejected to keep the draw uniform.
    assign j      = lfsr[KW-1:0];
    assign accept = (j <= i);
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
`ifdef ROW_SHUFFLER_IDENTITY_EN
                    state_nxt = EMIT;
`else
                    state_nxt = (W == 1) ? EMIT : PICK;
`endif
                end
            end
`ifndef ROW_SHUFFLER_IDENTITY_EN
            PICK: begin
                if (accept && (i == KW'(1))) begin
                    state_nxt = EMIT;
                end
            end
`endif
            EMIT: begin
                if (k == LAST) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        if (!reset) begin
            lfsr <= SEED_EFF;
            k    <= '0;
            for (int n = 0; n < W; n++) begin
                pool[n] <= W'(1) << n;
            end
`ifndef ROW_SHUFFLER_IDENTITY_EN
            i <= LAST;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        k <= '0;
                        for (int n = 0; n < W; n++) begin
                            pool[n] <= W'(1) << n;
                        end
`ifndef ROW_SHUFFLER_IDENTITY_EN
                        i <= LAST;
`endif
                    end
                end
`ifndef ROW_SHUFFLER_IDENTITY_EN
                PICK: begin
                    if (accept) begin
                        pool[i] <= pool[j];
                        pool[j] <= pool[i];
                        i       <= i - KW'(1);
                    end
                end
`endif
                EMIT:    k <= k + KW'(1);
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only; the write bus is zero outside EMIT.
    assign busy     = (state != IDLE);
    assign wr_en    = (state == EMIT);
    assign done     = (state == FIN);
    assign wr_index = wr_en ? (W'(1) << k) : '0;
`ifdef ROW_SHUFFLER_IDENTITY_EN
    assign wr_value = wr_en ? (W'(1) << k) : '0;
`else
    assign wr_value = wr_en ? pool[k] : '0;
`endif

endmodule

// File: tb/tb_row_shuffler.sv
// tb/tb_row_shuffler.sv - self-checking bench for row_shuffler (W = 9, 4, 1)
module tb_row_shuffler;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       start4;
    logic       start1;
    logic       busy, wr_en, done;
    logic [8:0] wr_index, wr_value;
    logic       busy4, wr_en4, done4;
    logic [3:0] wr_index4, wr_value4;
    logic       busy1, wr_en1, done1;
    logic [0:0] wr_index1, wr_value1;

    always #5 clock = ~clock;

    row_shuffler #(.W(9)) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .wr_en(wr_en),
        .wr_index(wr_index), .wr_value(wr_value), .done(done)
    );
    row_shuffler #(.W(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .busy(busy4), .wr_en(wr_en4),
        .wr_index(wr_index4), .wr_value(wr_value4), .done(done4)
    );
    row_shuffler #(.W(1)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .busy(busy1), .wr_en(wr_en1),
        .wr_index(wr_index1), .wr_value(wr_value1), .done(done1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input logic ok, input string name, input int act, input int want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Reference LFSR, tracked from the bench's own view of reset
    logic [15:0] m_lfsr;
    logic        rst_seen = 1'b1;
    always @(posedge clock) begin
        m_lfsr   <= reset ? nxt(m_lfsr) : SEED;
        rst_seen <= reset;
    end

    logic [8:0] pm [9];
    int         pred_picks;

    task automatic predict(input logic [15:0] l0);
        logic [15:0] l;
        logic [8:0]  tmp;
        int          i;
        int          j;
        l = l0;
        i = 8;
        pred_picks = 0;
        for (int n = 0; n < 9; n++) pm[n] = 9'(1) << n;
`ifndef ROW_SHUFFLER_IDENTITY_EN
        while (i >= 1 && pred_picks < 10000) begin
            j = int'(l[3:0]);
            if (j <= i) begin
                tmp   = pm[i];
                pm[i] = pm[j];
                pm[j] = tmp;
                i--;
            end
            pred_picks++;
            l = nxt(l);
        end
`endif
    endtask

    typedef struct packed {
        logic [8:0] idx;
        logic [8:0] val;
    } wr_t;
    wr_t exp_q [$];

    int         wr_cnt   = 0;
    int         done_cnt = 0;
    int         run_cyc  = 0;
    logic       busy_prev = 1'b0;
    logic [8:0] run_or;
    logic [8:0] cap [9];
    bit         seen [9][9];

    // Scoreboard: expectations pushed when a run launches, popped on each write
    always @(negedge clock) begin
        wr_t e;
        int  p;
        if (!rst_seen) begin
            chk(!busy && !wr_en && !done && wr_index == 0 && wr_value == 0,
                "reset_outputs", {busy, wr_en, done, wr_index, wr_value}, 0);
            exp_q.delete();
        end else begin
            if (busy && !busy_prev) begin
                predict(m_lfsr);
                for (int n = 0; n < 9; n++) exp_q.push_back({9'(1) << n, pm[n]});
                run_cyc = 0;
                run_or  = '0;
            end
            if (wr_en) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "extra_write", int'(wr_index), 0);
                end else begin
                    p = 9 - exp_q.size();
                    e = exp_q.pop_front();
                    chk(wr_index == e.idx, "wr_index", int'(wr_index), int'(e.idx));
                    chk(wr_value == e.val, "wr_value", int'(wr_value), int'(e.val));
                    chk($onehot(wr_value), "onehot", int'(wr_value), 1);
                    chk((wr_value & run_or) == 0, "repeat", int'(wr_value), int'(run_or));
                    chk(run_cyc == pred_picks + p, "write_timing", run_cyc, pred_picks + p);
                    cap[p] = wr_value;
                    for (int v = 0; v < 9; v++) if (wr_value[v]) seen[p][v] = 1'b1;
                end
                run_or = run_or | wr_value;
            end else begin
                chk(wr_index == 0 && wr_value == 0, "idle_bus", int'({wr_index, wr_value}), 0);
            end
            if (done) begin
                done_cnt++;
                chk(!wr_en, "done_with_wr", 1, 0);
                chk(exp_q.size() == 0 && run_cyc == pred_picks + 9, "done_timing",
                    run_cyc, pred_picks + 9);
                chk(run_or == 9'h1FF, "perm_or", int'(run_or), 'h1FF);
            end
            if (run_cyc == pred_picks + 10) begin
                chk(!busy, "busy_fall", int'(busy), 0);
            end
            run_cyc++;
        end
        busy_prev = busy;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
    endtask

    task automatic wait_done(input int lim);
        int n = 0;
        while (!done && n < lim) begin
            cyc();
            n++;
        end
        chk(done, "wait_done", int'(done), 1);
    endtask

    task automatic wait_wr(input int lim);
        int n = 0;
        while (!wr_en && n < lim) begin
            cyc();
            n++;
        end
        chk(wr_en, "wait_wr", int'(wr_en), 1);
    endtask

    // kind: 0 plain run, 1 stray start mid-PICK, 2 stray start mid-EMIT
    typedef struct {
        int delay;
        int kind;
        int exp_writes;
        int exp_dones;
    } vec_t;

    vec_t       tbl [5];
    logic [8:0] perms [5][9];

    initial begin
        int w0, d0, n;
        logic [3:0] or4;
        int cnt4;
        logic seen_done;
        reset  = 1'b0;
        start  = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;

        // Reset held with start high: outputs stay zero, then busy the cycle after
        repeat (3) cyc();
        chk(!busy, "busy_in_reset", int'(busy), 0);
        reset = 1'b1;
        cyc();
        chk(busy, "busy_after_start", int'(busy), 1);
        start = 1'b0;
        wait_done(200);
        cyc();

        tbl[0] = '{3, 0, 9, 1};
        tbl[1] = '{3, 0, 9, 1};
        tbl[2] = '{0, 1, 9, 1};
        tbl[3] = '{5, 2, 9, 1};
        tbl[4] = '{11, 0, 9, 1};
        for (int t = 0; t < 5; t++) begin
            do_reset();
            repeat (tbl[t].delay) cyc();
            w0 = wr_cnt;
            d0 = done_cnt;
            start = 1'b1;
            cyc();
            start = 1'b0;
            if (tbl[t].kind == 1) begin
                cyc();
                start = 1'b1;
                cyc();
                start = 1'b0;
            end else if (tbl[t].kind == 2) begin
                wait_wr(200);
                start = 1'b1;
                cyc();
                start = 1'b0;
            end
            wait_done(200);
            repeat (3) cyc();
            chk(!busy, "no_extra_run", int'(busy), 0);
            chk(wr_cnt - w0 == tbl[t].exp_writes, "run_writes", wr_cnt - w0, tbl[t].exp_writes);
            chk(done_cnt - d0 == tbl[t].exp_dones, "run_dones", done_cnt - d0, tbl[t].exp_dones);
            for (int p = 0; p < 9; p++) perms[t][p] = cap[p];
        end
        n = 0;
        for (int p = 0; p < 9; p++) if (perms[0][p] != perms[1][p]) n++;
        chk(n == 0, "determinism", n, 0);

        // Reset during the 4th write cycle abandons the run
        do_reset();
        w0 = wr_cnt;
        d0 = done_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_wr(200);
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        chk(!wr_en && !busy && !done, "reset_mid_emit", int'({wr_en, busy, done}), 0);
        chk(wr_cnt - w0 == 4 && done_cnt == d0, "partial_run", wr_cnt - w0, 4);
        reset = 1'b1;
        cyc();
        w0 = wr_cnt;
        start = 1'b1;
        cyc();
        start = 1'b0;
        wait_done(200);
        cyc();
        chk(wr_cnt - w0 == 9, "run_after_reset", wr_cnt - w0, 9);

        // 200 back-to-back runs with start held high
        w0 = wr_cnt;
        d0 = done_cnt;
        n  = 0;
        start = 1'b1;
        for (int c = 0; c < 20000 && n < 200; c++) begin
            cyc();
            if (done) n++;
        end
        start = 1'b0;
        repeat (3) cyc();
        chk(done_cnt - d0 == 200, "b2b_dones", done_cnt - d0, 200);
        chk(wr_cnt - w0 == 1800, "b2b_writes", wr_cnt - w0, 1800);
        chk(!busy, "b2b_idle", int'(busy), 0);
`ifndef ROW_SHUFFLER_IDENTITY_EN
        n = 0;
        for (int p = 0; p < 9; p++) for (int v = 0; v < 9; v++) if (!seen[p][v]) n++;
        chk(n == 0, "slot_coverage", n, 0);
`endif

        // W = 1: single write then done
        start1 = 1'b1;
        cyc();
        start1 = 1'b0;
        chk(busy1 && wr_en1 && wr_index1 == 1'b1 && wr_value1 == 1'b1 && !done1, "w1_write",
            int'({busy1, wr_en1, wr_index1, wr_value1, done1}), 'b11110);
        cyc();
        chk(done1 && !wr_en1, "w1_done", int'({done1, wr_en1}), 'b10);
        cyc();
        chk(!busy1, "w1_idle", int'(busy1), 0);

        // W = 4: four ascending writes covering every value
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        or4 = '0;
        cnt4 = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            if (wr_en4) begin
                chk(wr_index4 == 4'(4'b0001 << cnt4), "w4_index", int'(wr_index4), 1 << cnt4);
                or4 = or4 | wr_value4;
                cnt4++;
            end
            if (done4) seen_done = 1'b1;
            else cyc();
        end
        chk(seen_done, "w4_done", int'(seen_done), 1);
        chk(cnt4 == 4, "w4_writes", cnt4, 4);
        chk(or4 == 4'hF, "w4_or", int'(or4), 'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
